// File: rtl/accum_feeder.sv
// accum_feeder: FIFO-buffered word issuer for the 32-bit accumulator with shadow-sum checking
module accum_feeder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             enable,
  output logic [31:0]      value,
  input  logic [7:0]       led,
  output logic             busy,
  output logic [31:0]      shadow_sum,
  output logic [CNT_W-1:0] issued_count,
  output logic             mismatch
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, ADD} state_t;
  state_t           state_q;
  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             enable_q, mismatch_q, chk_q;
  logic [31:0]      value_q, shadow_q;
  logic [CNT_W-1:0] issued_q;
  logic             push, pop;
  assign in_ready     = cnt_q != (AW+1)'(DEPTH);
  assign push         = in_valid && in_ready;
  assign pop          = state_q == IDLE && cnt_q != '0;
  assign cnt_d        = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign busy         = state_q != IDLE || cnt_q != '0;
  assign enable       = enable_q;
  assign value        = value_q;
  assign shadow_sum   = shadow_q;
  assign issued_count = issued_q;
  assign mismatch     = mismatch_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      enable_q   <= 1'b0;
      value_q    <= '0;
      shadow_q   <= '0;
      issued_q   <= '0;
      mismatch_q <= 1'b0;
      chk_q      <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= in_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
      // led is compared one cycle after ADD, once the accumulator has absorbed the word
      chk_q      <= state_q == ADD;
      mismatch_q <= mismatch_q | (chk_q && led != shadow_q[23:16]);
      case (state_q)
        IDLE: begin
          enable_q <= pop;
          if (pop) begin
            value_q <= mem_q[rd_q];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          enable_q <= 1'b0;
          state_q  <= HOLD;
        end
        HOLD: state_q <= ADD;
        ADD: begin
          shadow_q <= shadow_q + value_q;
          issued_q <= issued_q + 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_accum_feeder.sv
// tb_accum_feeder: directed checks of accum_feeder against a behavioural accumulator model
module tb_accum_feeder;
  logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_ready, enable, busy, mismatch;
  logic [31:0] in_data = '0, value, shadow_sum;
  logic [7:0]  led;
  logic [15:0] issued_count;
  int          tests = 0, fails = 0, cyc = 0, idx;
  logic        force_led = 1'b0, saw_full, acc;
  logic [1:0]  acc_st = '0;
  logic [31:0] acc_cnt = '0;
  logic [31:0] words [6];
  logic [31:0] iss_v [$];
  int          iss_c [$];

  accum_feeder #(.DEPTH(4), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .enable(enable), .value(value), .led(led), .busy(busy), .shadow_sum(shadow_sum),
    .issued_count(issued_count), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      acc_st  <= '0;
      acc_cnt <= '0;
    end else begin
      if (acc_st == 2'd0 && enable) acc_st <= 2'd1;
      if (acc_st == 2'd1) acc_st <= 2'd2;
      if (acc_st == 2'd2) begin
        acc_cnt <= acc_cnt + value;
        acc_st  <= 2'd0;
      end
    end
  end
  assign led = force_led ? 8'h55 : acc_cnt[23:16];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (enable) begin
      iss_v.push_back(value);
      iss_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 60 && busy; i++) tick;
    chk("idle_timeout", busy, 1'b0);
    tick;
  endtask

  initial begin
    for (int k = 0; k < 6; k++) words[k] = 32'h0001_0000 + k;
    do_reset;
    chk("rst_enable", enable, 1'b0);
    chk("rst_value", value, 32'h0);
    chk("rst_shadow", shadow_sum, 32'h0);
    chk("rst_issued", issued_count, 16'h0);
    chk("rst_mismatch", mismatch, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    push_one(32'h0001_0000);
    chk("t1_enable_idle", enable, 1'b0);
    chk("t1_busy", busy, 1'b1);
    tick;
    chk("t1_enable_issue", enable, 1'b1);
    chk("t1_value_issue", value, 32'h0001_0000);
    tick;
    chk("t1_enable_hold", enable, 1'b0);
    chk("t1_value_hold", value, 32'h0001_0000);
    tick;
    chk("t1_enable_add", enable, 1'b0);
    chk("t1_value_add", value, 32'h0001_0000);
    tick;
    chk("t1_shadow", shadow_sum, 32'h0001_0000);
    chk("t1_issued", issued_count, 16'd1);
    chk("t1_led", led, 8'h01);
    chk("t1_value_kept", value, 32'h0001_0000);
    tick;
    chk("t1_mismatch", mismatch, 1'b0);
    chk("t1_busy_done", busy, 1'b0);
    iss_v.delete();
    iss_c.delete();
    idx = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 80; c++) begin
      in_valid = idx < 6;
      in_data  = idx < 6 ? words[idx] : 32'h0;
      if (!in_ready) saw_full = 1'b1;
      acc = in_valid && in_ready;
      tick;
      if (acc) idx++;
      if (idx == 6 && !busy) break;
    end
    in_valid = 1'b0;
    tick;
    chk("t2_pushed", idx, 6);
    chk("t2_full_seen", saw_full, 1'b1);
    chk("t2_issue_count", iss_v.size(), 6);
    for (int k = 0; k < 6 && k < iss_v.size(); k++) chk("t2_order", iss_v[k], words[k]);
    for (int k = 1; k < 6 && k < iss_c.size(); k++) chk("t2_spacing", iss_c[k] - iss_c[k-1], 4);
    chk("t2_shadow", shadow_sum, 32'h0007_000F);
    chk("t2_issued", issued_count, 16'd7);
    chk("t2_busy", busy, 1'b0);
    chk("t2_mismatch", mismatch, 1'b0);
    do_reset;
    push_one(32'hFFFF_0000);
    push_one(32'h0002_0000);
    wait_idle;
    chk("t3_shadow", shadow_sum, 32'h0001_0000);
    chk("t3_led", led, 8'h01);
    chk("t3_issued", issued_count, 16'd2);
    chk("t3_mismatch", mismatch, 1'b0);
    push_one(32'h0);
    tick;
    tick;
    tick;
    tick;
    chk("t4_shadow_pre", shadow_sum, 32'h0001_0000);
    chk("t4_mismatch_pre", mismatch, 1'b0);
    force_led = 1'b1;
    tick;
    force_led = 1'b0;
    chk("t4_mismatch_set", mismatch, 1'b1);
    push_one(32'h0001_0000);
    wait_idle;
    chk("t4_shadow_post", shadow_sum, 32'h0002_0000);
    chk("t4_led_post", led, 8'h02);
    chk("t4_mismatch_sticky", mismatch, 1'b1);
    push_one(32'h0003_0000);
    push_one(32'h0004_0000);
    tick;
    chk("t5_in_hold", enable, 1'b0);
    chk("t5_busy_pre", busy, 1'b1);
    do_reset;
    chk("t5_enable", enable, 1'b0);
    chk("t5_value", value, 32'h0);
    chk("t5_shadow", shadow_sum, 32'h0);
    chk("t5_issued", issued_count, 16'h0);
    chk("t5_in_ready", in_ready, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_mismatch", mismatch, 1'b0);
    tick;
    tick;
    chk("t5_no_issue", enable, 1'b0);
    chk("t5_still_idle", busy, 1'b0);
    iss_v.delete();
    push_one(32'h0010_0001);
    push_one(32'h0010_0002);
    push_one(32'h0010_0003);
    tick;
    tick;
    chk("t6_idle_ready", in_ready, 1'b1);
    push_one(32'h0010_0004);
    chk("t6_popped", enable, 1'b1);
    push_one(32'h0010_0005);
    chk("t6_ready_3", in_ready, 1'b1);
    push_one(32'h0010_0006);
    chk("t6_full", in_ready, 1'b0);
    wait_idle;
    chk("t6_issue_count", iss_v.size(), 6);
    for (int k = 0; k < 6 && k < iss_v.size(); k++) chk("t6_order", iss_v[k], 32'h0010_0001 + k);
    chk("t6_shadow", shadow_sum, 32'h0060_0015);
    chk("t6_led", led, 8'h60);
    chk("t6_mismatch", mismatch, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
